// File: rtl/fetch_pkg.sv
// Shared fetch front-end types: FSM encoding, datapath widths and the queue entry.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int IMM_W   = 16;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc_plus4;
  } entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order circular buffer of fetched entries; a push is visible at the head one clock later.
// No backpressure port: pushes when full and pops when empty are ignored; flush empties it in one clock.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   core_clk,
  input  logic                   arst_n,
  input  logic                   flush,
  input  logic                   push_vld,
  input  entry_t                 push_dat,
  input  logic                   pop_rdy,
  output entry_t                 head_dat,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          push;
  logic          pop;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign push     = push_vld && !full;
  assign pop      = pop_rdy && !empty;
  assign head_dat = mem[rd_ptr];

  // Flush only rewinds pointers; stale payload stays so the outputs do not glitch.
  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS fetch front end: one outstanding imem fetch, queued {instr, pc+4} to decode; gnt->id_valid_o 2 clocks (1 with FETCH_BYPASS_EN).
// Requests stall while the queue would overflow; redirects flush the queue and drop the in-flight fetch.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               imem_req_o,
  output logic [31:0]        imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  output logic               id_valid_o,
  input  logic               id_ready_i,
  output logic [INSTR_W-1:0] id_instr_o,
  output logic [31:0]        id_pc_plus4_o,
  output logic [IMM_W-1:0]   id_imm_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t  state, state_nxt;
  logic [31:0]   pc, pc_nxt, fetch_pc, fetch_pc_nxt, target;
  logic          push_vld, pop_rdy, q_empty, byp_vld, req_nxt;
  logic [CW-1:0] q_count, count_nxt;
  entry_t        push_dat, head_dat;

  assign target   = {redirect_pc_i[31:2], 2'b00};
  assign push_dat = '{instr: imem_rdata_i, pc_plus4: fetch_pc + 32'd4};
  assign pop_rdy  = id_ready_i && !q_empty;

`ifdef FETCH_BYPASS_EN
  // An empty queue lets a clean response reach decode in its arrival cycle.
  assign byp_vld       = q_empty && (state == S_WAIT) && imem_rvalid_i && !redirect_i;
  assign id_valid_o    = !q_empty || byp_vld;
  assign id_instr_o    = byp_vld ? imem_rdata_i : head_dat.instr;
  assign id_pc_plus4_o = byp_vld ? push_dat.pc_plus4 : head_dat.pc_plus4;
`else
  assign byp_vld       = 1'b0;
  assign id_valid_o    = !q_empty;
  assign id_instr_o    = head_dat.instr;
  assign id_pc_plus4_o = head_dat.pc_plus4;
`endif
  assign id_imm_o = id_instr_o[IMM_W-1:0];

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    fetch_pc_nxt = fetch_pc;
    push_vld     = 1'b0;
    case (state)
      S_REQ: begin
        if (imem_req_o && imem_gnt_i) begin
          fetch_pc_nxt = pc;
          pc_nxt       = pc + 32'd4;
          state_nxt    = redirect_i ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          state_nxt = S_REQ;
          push_vld  = !redirect_i && !(byp_vld && id_ready_i);
        end else if (redirect_i) begin
          state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid_i) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
    if (redirect_i) pc_nxt = target;
    // req is registered, so gate it on the occupancy the queue will have next cycle.
    count_nxt = redirect_i ? '0 : q_count + CW'(push_vld) - CW'(pop_rdy);
    req_nxt   = (state_nxt == S_REQ) && (count_nxt < DEPTH_C);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      fetch_pc    <= '0;
      imem_req_o  <= 1'b0;
      imem_addr_o <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      fetch_pc    <= fetch_pc_nxt;
      imem_req_o  <= req_nxt;
      imem_addr_o <= pc_nxt;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .core_clk (clk_i),
    .arst_n   (rst_i),
    .flush    (redirect_i),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop_rdy  (pop_rdy),
    .head_dat (head_dat),
    .count    (q_count),
    .empty    (q_empty)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed corner sequences, a redirect-target table, then a randomized run
// scored against an in-order fetch-stream model (expected next address, advanced by 4, reset by redirects).
module tb_instr_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o, id_ready_i;
  logic [31:0] id_instr_o, id_pc_plus4_o;
  logic [15:0] id_imm_o;

  instr_fetch_unit dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_instr_o(id_instr_o),
    .id_pc_plus4_o(id_pc_plus4_o), .id_imm_o(id_imm_o)
  );

  always #5 clk_i = ~clk_i;

`ifdef FETCH_BYPASS_EN
  localparam int FIRST_V = 2;
`else
  localparam int FIRST_V = 3;
`endif

  typedef struct packed {
    logic [31:0] rpc;
    logic [31:0] addr;
  } vec_t;
  vec_t tbl [5];

  int vectors = 0, miscompares = 0;
  bit mem_auto;
  int gnt_pct, lat_max, lat;
  bit pend;
  logic [31:0] pend_addr;
  logic nx_gnt, nx_rvalid, nx_ready, nx_redir;
  logic [31:0] nx_rdata, nx_rpc;
  logic [31:0] exp_addr;
  int delivered, d0, first_v;
  bit hold;
  logic [31:0] hold_instr, hold_pc4, a;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic sb_reset();
    exp_addr = 32'h0;
    pend = 1'b0;
    hold = 1'b0;
  endtask

  // One clock: drive inputs just after the edge, sample and score at the falling edge.
  task automatic step();
    bit was_pend;
    @(posedge clk_i); #1;
    imem_gnt_i = nx_gnt; imem_rvalid_i = nx_rvalid; imem_rdata_i = nx_rdata;
    if (mem_auto) begin
      imem_rvalid_i = pend && (lat == 0);
      imem_rdata_i  = imem_rvalid_i ? mem_word(pend_addr) : $urandom;
      imem_gnt_i    = imem_req_o && ($urandom_range(0, 99) < gnt_pct);
    end
    id_ready_i = nx_ready; redirect_i = nx_redir; redirect_pc_i = nx_rpc;
    @(negedge clk_i);
    if (hold) begin
      chk("hold_valid", 32'(id_valid_o), 32'd1);
      chk("hold_instr", id_instr_o, hold_instr);
      chk("hold_pc4", id_pc_plus4_o, hold_pc4);
    end
    was_pend = pend;
    if (imem_req_o) chk("single_outstanding", 32'(was_pend), 32'd0);
    if (id_valid_o && id_ready_i) begin
      chk("dec_instr", id_instr_o, mem_word(exp_addr));
      chk("dec_pc4", id_pc_plus4_o, exp_addr + 32'd4);
      chk("dec_imm", 32'(id_imm_o), 32'(mem_word(exp_addr) & 32'hFFFF));
      exp_addr += 32'd4;
      delivered++;
    end
    if (redirect_i) exp_addr = {redirect_pc_i[31:2], 2'b00};
    hold = id_valid_o && !id_ready_i && !redirect_i;
    hold_instr = id_instr_o;
    hold_pc4   = id_pc_plus4_o;
    if (imem_rvalid_i) pend = 1'b0;
    else if (pend && lat > 0) lat--;
    if (imem_req_o && imem_gnt_i) begin
      pend = 1'b1;
      pend_addr = imem_addr_o;
      lat = $urandom_range(0, lat_max);
    end
  endtask

  // Drain to an idle S_REQ: no grants, wait for the pending response and an empty queue.
  task automatic wait_idle();
    bit ok = 1'b0;
    gnt_pct = 0; nx_ready = 1'b1;
    for (int k = 0; k < 30 && !ok; k++) begin
      step();
      ok = imem_req_o && !pend && !id_valid_o;
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
    mem_auto = 1'b0; nx_gnt = 1'b0; nx_rvalid = 1'b0;
  endtask

  initial begin
    tbl[0] = '{32'h0000_0103, 32'h0000_0100};
    tbl[1] = '{32'h0000_0040, 32'h0000_0040};
    tbl[2] = '{32'h0000_0007, 32'h0000_0004};
    tbl[3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC};
    tbl[4] = '{32'h0000_02A1, 32'h0000_02A0};

    rst_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    redirect_i = 1'b0; redirect_pc_i = '0; id_ready_i = 1'b0;
    nx_gnt = 1'b0; nx_rvalid = 1'b0; nx_ready = 1'b0; nx_redir = 1'b0; nx_rdata = '0; nx_rpc = '0;
    mem_auto = 1'b0; gnt_pct = 100; lat_max = 0; lat = 0; delivered = 0;
    sb_reset();

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_addr", imem_addr_o, 32'd0);
    chk("rst_valid", 32'(id_valid_o), 32'd0);
    chk("rst_instr", id_instr_o, 32'd0);
    chk("rst_pc4", id_pc_plus4_o, 32'd0);
    chk("rst_imm", 32'(id_imm_o), 32'd0);

    // Reset release with a single-cycle memory that grants immediately.
    mem_auto = 1'b1; nx_ready = 1'b1; first_v = -1;
    @(posedge clk_i); #1; rst_i = 1'b1; id_ready_i = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 1) begin
        chk("first_req", 32'(imem_req_o), 32'd1);
        chk("first_addr", imem_addr_o, 32'h0);
      end
      if (c == 3) begin
        chk("second_req", 32'(imem_req_o), 32'd1);
        chk("second_addr", imem_addr_o, 32'h4);
      end
      if (id_valid_o && first_v < 0) first_v = c;
    end
    chk("first_valid_cycle", first_v, FIRST_V);
    chk("boot_delivered", 32'(delivered >= 3), 32'd1);

    // Decode stall: queue fills, fetch stops, head held; one pop reopens fetch.
    nx_ready = 1'b0;
    repeat (10) step();
    chk("full_req", 32'(imem_req_o), 32'd0);
    chk("full_valid", 32'(id_valid_o), 32'd1);
    chk("full_head", id_instr_o, mem_word(exp_addr));
    repeat (3) step();
    chk("full_req_held", 32'(imem_req_o), 32'd0);
    nx_ready = 1'b1; step();
    nx_ready = 1'b0; step();
    chk("req_after_pop", 32'(imem_req_o), 32'd1);
    nx_ready = 1'b1;
    wait_idle();

    // Redirect while waiting; the late response must be dropped.
    nx_gnt = 1'b1; step();
    nx_gnt = 1'b0; nx_redir = 1'b1; nx_rpc = 32'h40; step();
    nx_redir = 1'b0; step();
    chk("drop_no_req", 32'(imem_req_o), 32'd0);
    nx_rvalid = 1'b1; nx_rdata = 32'hDEAD_BEEF; step();
    chk("drop_valid", 32'(id_valid_o), 32'd0);
    nx_rvalid = 1'b0; step();
    chk("redir_req", 32'(imem_req_o), 32'd1);
    chk("redir_addr", imem_addr_o, 32'h40);
    chk("redir_empty", 32'(id_valid_o), 32'd0);
    d0 = delivered;
    nx_gnt = 1'b1; step();
    nx_gnt = 1'b0;
    chk("redir_empty_wait", 32'(id_valid_o), 32'd0);
    nx_rvalid = 1'b1; nx_rdata = mem_word(32'h40); step();
    nx_rvalid = 1'b0; step();
    chk("redir_delivered", delivered - d0, 32'd1);

    // Redirect coinciding with the response.
    nx_gnt = 1'b1; step();
    nx_gnt = 1'b0; nx_rvalid = 1'b1; nx_rdata = mem_word(32'h44); nx_redir = 1'b1; nx_rpc = 32'h80; step();
    chk("rv_redir_valid", 32'(id_valid_o), 32'd0);
    nx_rvalid = 1'b0; nx_redir = 1'b0; step();
    chk("rv_redir_req", 32'(imem_req_o), 32'd1);
    chk("rv_redir_addr", imem_addr_o, 32'h80);
    chk("rv_redir_empty", 32'(id_valid_o), 32'd0);

    // Redirect targets, including misaligned ones and address wrap.
    for (int i = 0; i < 5; i++) begin
      nx_redir = 1'b1; nx_rpc = tbl[i].rpc; step();
      nx_redir = 1'b0; nx_gnt = 1'b1; step();
      chk("tbl_req", 32'(imem_req_o), 32'd1);
      chk("tbl_addr", imem_addr_o, tbl[i].addr);
      nx_gnt = 1'b0; nx_rvalid = 1'b1; nx_rdata = mem_word(tbl[i].addr); nx_ready = 1'b0; step();
      nx_rvalid = 1'b0; nx_ready = 1'b1; step();
      chk("tbl_valid", 32'(id_valid_o), 32'd1);
      chk("tbl_pc4", id_pc_plus4_o, tbl[i].addr + 32'd4);
      chk("tbl_instr", id_instr_o, mem_word(tbl[i].addr));
      step();
      chk("tbl_drained", 32'(id_valid_o), 32'd0);
    end

    // Reset pulse in S_WAIT with one queued entry.
    a = imem_addr_o;
    nx_ready = 1'b0; nx_gnt = 1'b1; step();
    nx_gnt = 1'b0; nx_rvalid = 1'b1; nx_rdata = mem_word(a); step();
    nx_rvalid = 1'b0; nx_gnt = 1'b1; step();
    chk("pre_rst_valid", 32'(id_valid_o), 32'd1);
    @(posedge clk_i); #1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
    #2; rst_i = 1'b0; #1;
    chk("async_rst_valid", 32'(id_valid_o), 32'd0);
    chk("async_rst_req", 32'(imem_req_o), 32'd0);
    @(posedge clk_i); #1; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    @(posedge clk_i); #1; rst_i = 1'b1;
    sb_reset();
    mem_auto = 1'b1; gnt_pct = 100; lat_max = 0; nx_ready = 1'b1; nx_gnt = 1'b0; nx_rvalid = 1'b0;
    d0 = delivered;
    step();
    chk("restart_req", 32'(imem_req_o), 32'd1);
    chk("restart_addr", imem_addr_o, 32'h0);
    repeat (6) step();
    chk("restart_delivered", 32'(delivered - d0 >= 2), 32'd1);

    // Randomized traffic against the stream model.
    gnt_pct = 70; lat_max = 2; d0 = delivered;
    for (int n = 0; n < 2000; n++) begin
      nx_ready = ($urandom_range(0, 2) != 0);
      nx_redir = ($urandom_range(0, 19) == 0);
      nx_rpc   = $urandom_range(0, 1023);
      step();
    end
    chk("random_progress", 32'(delivered - d0 > 100), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
